// File: rtl/drc_frm_upscaler.sv
// 2x nearest-neighbour frame upscaler with valid/ready on both sides.
// The first copy of each row streams straight through; the second copy replays from a line buffer.
module drc_frm_upscaler #(
    parameter int I_PXL_W = 8,
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [I_PXL_W-1:0] bwd_pxl_data_i,
    input  logic               bwd_pxl_last_i,
    input  logic               bwd_pxl_vld_i,
    output logic               bwd_pxl_rdy_o,
    output logic [I_PXL_W-1:0] fwd_pxl_data_o,
    output logic               fwd_pxl_last_o,
    output logic               fwd_pxl_vld_o,
    input  logic               fwd_pxl_rdy_i
);

    localparam int COLS = COL_NUM / 2;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    // Odd geometry cannot be produced by a 2x upscale.
    if ((ROW_NUM % 2) != 0) begin : g_odd_rows_unsupported
    end
    if ((COL_NUM % 2) != 0) begin : g_odd_cols_unsupported
    end

    typedef enum logic {
        FIRST_ROW  = 1'b0,
        REPLAY_ROW = 1'b1
    } state_t;

    state_t             state_q;
    logic [I_PXL_W-1:0] pxl_q;
    logic               hold_q;
    logic               dup_q;
    logic               frame_last_q;
    logic [CW-1:0]      in_col;
    logic [CW-1:0]      rd_col;
    logic [I_PXL_W-1:0] line_buf [COLS];

    logic bwd_hsk;
    logic fwd_hsk;
    logic held_is_last_col;
    logic rd_last_col;

    // in_col has already wrapped once the last column pixel is held.
    assign held_is_last_col = hold_q & (in_col == '0);
    assign rd_last_col      = (rd_col == LAST_COL);

    always_comb begin
        bwd_pxl_rdy_o  = 1'b0;
        fwd_pxl_vld_o  = 1'b0;
        fwd_pxl_data_o = pxl_q;
        fwd_pxl_last_o = 1'b0;
        unique case (state_q)
            FIRST_ROW: begin
                bwd_pxl_rdy_o  = ~hold_q
                               | (dup_q & fwd_pxl_rdy_i & ~held_is_last_col);
                fwd_pxl_vld_o  = hold_q;
                fwd_pxl_data_o = pxl_q;
            end
            REPLAY_ROW: begin
                fwd_pxl_vld_o  = 1'b1;
                fwd_pxl_data_o = line_buf[rd_col];
                fwd_pxl_last_o = rd_last_col & dup_q & frame_last_q;
            end
            default: ;
        endcase
    end

    assign bwd_hsk = bwd_pxl_vld_i & bwd_pxl_rdy_o;
    assign fwd_hsk = fwd_pxl_vld_o & fwd_pxl_rdy_i;

    always_ff @(posedge clk) begin
        if (bwd_hsk) begin
            line_buf[in_col] <= bwd_pxl_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FIRST_ROW;
            pxl_q        <= '0;
            hold_q       <= 1'b0;
            dup_q        <= 1'b0;
            frame_last_q <= 1'b0;
            in_col       <= '0;
            rd_col       <= '0;
        end else begin
            unique case (state_q)
                FIRST_ROW: begin
                    if (bwd_hsk) begin
                        pxl_q        <= bwd_pxl_data_i;
                        hold_q       <= 1'b1;
                        dup_q        <= 1'b0;
                        frame_last_q <= bwd_pxl_last_i;
                        in_col       <= (in_col == LAST_COL) ? '0 : in_col + 1'b1;
                    end else if (fwd_hsk) begin
                        if (!dup_q) begin
                            dup_q <= 1'b1;
                        end else begin
                            hold_q <= 1'b0;
                            dup_q  <= 1'b0;
                            if (held_is_last_col) begin
                                state_q <= REPLAY_ROW;
                                rd_col  <= '0;
                            end
                        end
                    end
                end
                REPLAY_ROW: begin
                    if (fwd_hsk) begin
                        dup_q <= ~dup_q;
                        if (dup_q) begin
                            if (rd_last_col) begin
                                state_q      <= FIRST_ROW;
                                hold_q       <= 1'b0;
                                frame_last_q <= 1'b0;
                                rd_col       <= '0;
                            end else begin
                                rd_col <= rd_col + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= FIRST_ROW;
            endcase
        end
    end

endmodule

// File: tb/tb_drc_frm_upscaler.sv
// Directed bench for drc_frm_upscaler at 4x4 output geometry.
// Expected output pixels are queued when a row is driven and checked as they leave.
module tb_drc_frm_upscaler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] bwd_data;
    logic         bwd_last;
    logic         bwd_vld;
    logic         bwd_rdy;
    logic [W-1:0] fwd_data;
    logic         fwd_last;
    logic         fwd_vld;
    logic         fwd_rdy;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int cont_lo = 0;
    int cont_hi = 0;
    bit rnd_stall = 1'b0;
    logic [W:0] exp_q [$];

    drc_frm_upscaler #(
        .I_PXL_W(W),
        .COL_NUM(4),
        .ROW_NUM(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bwd_pxl_data_i(bwd_data),
        .bwd_pxl_last_i(bwd_last),
        .bwd_pxl_vld_i (bwd_vld),
        .bwd_pxl_rdy_o (bwd_rdy),
        .fwd_pxl_data_o(fwd_data),
        .fwd_pxl_last_o(fwd_last),
        .fwd_pxl_vld_o (fwd_vld),
        .fwd_pxl_rdy_i (fwd_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_row(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic last);
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({last, b});
    endtask

    task automatic send_pix(input logic [W-1:0] d, input logic l,
                            output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = 0;
        bwd_data = d;
        bwd_last = l;
        bwd_vld = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bwd_rdy) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                acc_cyc = cyc;
            end
        end
        chk("accept", 32'(ok), 32'd1);
        bwd_vld = 1'b0;
        bwd_last = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: while valid, output must match the queue head, even when stalled.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cyc >= cont_lo && cyc < cont_hi)
                chk("cont_vld", 32'(fwd_vld), 32'd1);
            if (fwd_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("extra_out", 32'(fwd_vld), 32'd0);
                end else begin
                    chk("out_data", 32'(fwd_data), 32'(exp_q[0][W-1:0]));
                    chk("out_last", 32'(fwd_last), 32'(exp_q[0][W]));
                    if (fwd_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        fwd_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            fwd_rdy = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int t0, t1, t2, t3;
        rst_n = 1'b0;
        bwd_vld = 1'b0;
        bwd_data = '0;
        bwd_last = 1'b0;
        #12;
        chk("rst_vld", 32'(fwd_vld), 32'd0);
        chk("rst_last", 32'(fwd_last), 32'd0);
        chk("rst_data", 32'(fwd_data), 32'd0);
        chk("rst_rdy", 32'(bwd_rdy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_vld", 32'(fwd_vld), 32'd0);
        chk("rel_rdy", 32'(bwd_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Full-rate frame, with input 30 offered throughout the replay.
        push_row(8'd10, 8'd20, 1'b0);
        push_row(8'd30, 8'd40, 1'b1);
        send_pix(8'd10, 1'b0, t0);
        cont_lo = t0;
        cont_hi = t0 + 8;
        send_pix(8'd20, 1'b0, t1);
        chk("bwd_gap_row1", 32'(t1 - t0), 32'd2);
        send_pix(8'd30, 1'b0, t2);
        chk("replay_block", 32'(t2 - t1), 32'd7);
        send_pix(8'd40, 1'b1, t3);
        chk("bwd_gap_row2", 32'(t3 - t2), 32'd2);
        wait_drain("drain_full_rate");

        // Same frame under random downstream stalls.
        rnd_stall = 1'b1;
        push_row(8'd10, 8'd20, 1'b0);
        push_row(8'd30, 8'd40, 1'b1);
        send_pix(8'd10, 1'b0, t0);
        send_pix(8'd20, 1'b0, t1);
        send_pix(8'd30, 1'b0, t2);
        send_pix(8'd40, 1'b1, t3);
        wait_drain("drain_stall");
        rnd_stall = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of the first row.
        push_row(8'd10, 8'd20, 1'b0);
        send_pix(8'd10, 1'b0, t0);
        send_pix(8'd20, 1'b0, t1);
        for (int i = 0; i < 50 && exp_q.size() > 5; i++) begin
            @(negedge clk);
        end
        chk("pre_rst_progress", 32'(exp_q.size()), 32'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(fwd_vld), 32'd0);
        chk("mid_rst_last", 32'(fwd_last), 32'd0);
        chk("mid_rst_data", 32'(fwd_data), 32'd0);
        chk("mid_rst_rdy", 32'(bwd_rdy), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_row(8'd50, 8'd60, 1'b0);
        push_row(8'd70, 8'd80, 1'b1);
        send_pix(8'd50, 1'b0, t0);
        send_pix(8'd60, 1'b0, t1);
        chk("post_rst_gap", 32'(t1 - t0), 32'd2);
        send_pix(8'd70, 1'b0, t2);
        send_pix(8'd80, 1'b1, t3);
        wait_drain("drain_after_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/drc_frm_upscaler.md
DRC_FRM_UPSCALER -- requirements
Module: drc_frm_upscaler

Interface
REQ-001 SHALL have parameter I_PXL_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter COL_NUM, default 640, output columns per row; even number, input row = COL_NUM/2 pixels.
REQ-003 SHALL have parameter ROW_NUM, default 480, output rows per frame; even number, input frame = ROW_NUM/2 rows.
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port bwd_pxl_data_i, input, I_PXL_W, incoming downscaled pixel.
REQ-007 SHALL have port bwd_pxl_last_i, input, 1, last pixel of the input frame.
REQ-008 SHALL have port bwd_pxl_vld_i, input, 1, incoming pixel valid.
REQ-009 SHALL have port bwd_pxl_rdy_o, output, 1, upscaler can accept a pixel.
REQ-010 SHALL have port fwd_pxl_data_o, output, I_PXL_W, upscaled output pixel.
REQ-011 SHALL have port fwd_pxl_last_o, output, 1, last pixel of the output frame.
REQ-012 SHALL have port fwd_pxl_vld_o, output, 1, output pixel valid.
REQ-013 SHALL have port fwd_pxl_rdy_i, input, 1, downstream ready.

Function
REQ-014 SHALL perform 2x nearest-neighbour upscaling: each input pixel emitted twice horizontally, each input row emitted twice vertically.
REQ-015 SHALL define handshakes: bwd_hsk = bwd_pxl_vld_i & bwd_pxl_rdy_o; fwd_hsk = fwd_pxl_vld_o & fwd_pxl_rdy_i; data/last transfer only on handshake.
REQ-016 SHALL implement a 2-state FSM: FIRST_ROW (consume input, emit, store to line buffer) and REPLAY_ROW (emit from line buffer, consume nothing).
REQ-017 SHALL contain a line buffer of COL_NUM/2 entries x I_PXL_W, written at address in_col on every bwd_hsk, read combinationally at address rd_col in REPLAY_ROW.
REQ-018 SHALL keep in FIRST_ROW a hold register (pxl_q, hold_q) and duplicate flag dup_q; on bwd_hsk: pxl_q <= data, hold_q <= 1, dup_q <= 0.
REQ-019 FIRST_ROW: fwd_pxl_vld_o = hold_q, fwd_pxl_data_o = pxl_q; fwd_hsk with dup_q=0 sets dup_q=1; fwd_hsk with dup_q=1 clears hold_q unless a bwd_hsk occurs in the same cycle.
REQ-020 FIRST_ROW: bwd_pxl_rdy_o = ~hold_q | (dup_q & fwd_pxl_rdy_i & ~held_is_last_col); zero-bubble, one output per cycle at full throughput.
REQ-021 SHALL increment in_col (width clog2(COL_NUM/2)) on bwd_hsk and wrap to 0 after COL_NUM/2-1.
REQ-022 SHALL transition FIRST_ROW->REPLAY_ROW on fwd_hsk of the second copy of the last-column pixel; rd_col <= 0, dup_q <= 0.
REQ-023 REPLAY_ROW: fwd_pxl_vld_o = 1, fwd_pxl_data_o = line_buffer[rd_col], bwd_pxl_rdy_o = 0; dup_q toggles per fwd_hsk; rd_col increments after the second copy.
REQ-024 SHALL transition REPLAY_ROW->FIRST_ROW on fwd_hsk of the second copy at rd_col = COL_NUM/2-1; hold_q = 0.
REQ-025 SHALL latch bwd_pxl_last_i into frame_last_q on bwd_hsk; clear it on REPLAY_ROW->FIRST_ROW.
REQ-026 SHALL drive fwd_pxl_last_o = 1 only in REPLAY_ROW, with rd_col = COL_NUM/2-1, dup_q = 1 and frame_last_q = 1; 0 otherwise, including the FIRST_ROW copy of that pixel.
REQ-027 SHALL hold fwd_pxl_data_o/fwd_pxl_last_o stable while fwd_pxl_vld_o=1 and fwd_pxl_rdy_i=0.
REQ-028 SHALL use no row counter for framing; the frame boundary is carried solely by bwd_pxl_last_i.

Reset
REQ-029 On rst_n=0, SHALL asynchronously set state=FIRST_ROW, hold_q=0, dup_q=0, in_col=0, rd_col=0, frame_last_q=0, pxl_q=0; line buffer contents are not reset.
REQ-030 During and right after reset SHALL output fwd_pxl_vld_o=0, fwd_pxl_last_o=0, fwd_pxl_data_o=0, bwd_pxl_rdy_o=1.
REQ-031 Reset asserted mid-row or mid-replay SHALL discard the partial row; first pixel after release is treated as column 0 of a FIRST_ROW.

Verification
REQ-032 COL_NUM=4, ROW_NUM=4, input 10,20,30,40 (last on 40), rdy=1 -> output 10,10,20,20,10,10,20,20,30,30,40,40,30,30,40,40; last only on 16th.
REQ-033 Continuous vld/rdy in FIRST_ROW -> fwd_pxl_vld_o=1 every cycle, bwd_pxl_rdy_o=1 on alternate cycles, no bubbles.
REQ-034 Random fwd_pxl_rdy_i stalls (50%) -> data/last stable during stall, sequence identical to REQ-032.
REQ-035 bwd_pxl_vld_i=1 throughout REPLAY_ROW -> bwd_pxl_rdy_o=0, no input consumed, input 30 accepted only after replay ends.
REQ-036 rst_n pulsed after output 20 (first row) -> vld=0 immediately; new frame 50,60,70,80 -> output starts 50,50,60,60.
